// File: rtl/pipe_stage_pkg.sv
// Shared types for the generic pipeline latch: FSM state encoding and occupancy width.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating stall / bubble / flush event counters for one pipeline latch.
module pipe_stage_perf
    import pipe_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall,
    input  logic             bubble,
    input  logic             flush_evt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (stall)     stall_cnt  <= sat_inc(stall_cnt);
            if (bubble)    bubble_cnt <= sat_inc(bubble_cnt);
            if (flush_evt) flush_cnt  <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline latch with optional 2-entry skid buffer, flush and occupancy.
// Define PIPE_STAGE_PERF_EN to add the stall/bubble/flush counter ports.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int                DATA_W     = 128,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                SKID       = 1,
    parameter int                CNT_W      = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    pipe_state_t       state_p1;
    logic [DATA_W-1:0] main_p1;
    logic [DATA_W-1:0] skid_p1;
    logic              rdy_p1;
    logic              in_fire;
    logic              out_fire;

    // main_p1 holds BUBBLE_VAL whenever the stage is empty, so it drives out_data directly
    assign out_valid = (state_p1 != PS_EMPTY);
    assign out_data  = main_p1;
    assign occupancy = state_p1;
    assign in_ready  = (SKID != 0) ? rdy_p1 : (rdy_p1 && (!out_valid || out_ready));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_p1 <= PS_EMPTY;
            main_p1  <= BUBBLE_VAL;
            skid_p1  <= BUBBLE_VAL;
            rdy_p1   <= 1'b0;
        end else if (flush) begin
            state_p1 <= PS_EMPTY;
            main_p1  <= BUBBLE_VAL;
            skid_p1  <= BUBBLE_VAL;
            rdy_p1   <= 1'b1;
        end else begin
            // rdy_p1 mirrors next_state != PS_FULL; only the FULL-bound paths clear it
            rdy_p1 <= 1'b1;
            unique case (state_p1)
                PS_EMPTY: begin
                    if (in_fire) begin
                        state_p1 <= PS_BUSY;
                        main_p1  <= in_data;
                    end
                end
                PS_BUSY: begin
                    if (in_fire && out_ready) begin
                        main_p1 <= in_data;
                    end else if (in_fire && (SKID != 0)) begin
                        state_p1 <= PS_FULL;
                        skid_p1  <= in_data;
                        rdy_p1   <= 1'b0;
                    end else if (out_fire) begin
                        state_p1 <= PS_EMPTY;
                        main_p1  <= BUBBLE_VAL;
                    end
                end
                PS_FULL: begin
                    if (out_fire) begin
                        state_p1 <= PS_BUSY;
                        main_p1  <= skid_p1;
                        skid_p1  <= BUBBLE_VAL;
                    end else begin
                        rdy_p1 <= 1'b0;
                    end
                end
                default: begin
                    state_p1 <= PS_EMPTY;
                    main_p1  <= BUBBLE_VAL;
                    skid_p1  <= BUBBLE_VAL;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_perf #(
        .CNT_W(CNT_W)
    ) u_perf (
        .CLK       (CLK),
        .RST       (RST),
        .stall     (out_valid && !out_ready),
        .bubble    (!out_valid),
        .flush_evt (flush),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share directed stimulus and are
// checked every cycle against queue-based models, plus hand-computed literal expectations.
module tb_pipe_stage_reg;

    localparam int          DW    = 16;
    localparam logic [15:0] BUB   = 16'hDEAD;
    localparam int          CW    = 4;
    localparam int          CMAX  = 15;

    logic          CLK;
    logic          RST;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_ready;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [1:0]    occ1, occ0;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall1, bubble1, flushc1, stall0, bubble0, flushc0;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID(1), .CNT_W(CW)) u_dut1 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .flush(flush), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall1), .bubble_cnt(bubble1), .flush_cnt(flushc1)
`endif
    );

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID(0), .CNT_W(CW)) u_dut0 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .flush(flush), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall0), .bubble_cnt(bubble0), .flush_cnt(flushc0)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: each stage is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] got1[$];
    logic [DW-1:0] got0[$];
    bit            live    = 0;
    bit            started = 0;
    int            m_st1 = 0, m_bb1 = 0, m_fl1 = 0, m_st0 = 0, m_bb0 = 0, m_fl0 = 0;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic bit exp_rdy1();
        return started && (q1.size() < 2);
    endfunction

    function automatic bit exp_rdy0();
        return started && ((q0.size() == 0) || out_ready);
    endfunction

    always @(posedge CLK) begin
        bit r1, r0, of1, of0;
        r1  = exp_rdy1();
        r0  = exp_rdy0();
        of1 = (q1.size() > 0) && out_ready;
        of0 = (q0.size() > 0) && out_ready;
        if (RST) begin
            q1.delete();
            q0.delete();
            started = 0;
            live    = 1;
            m_st1 = 0; m_bb1 = 0; m_fl1 = 0;
            m_st0 = 0; m_bb0 = 0; m_fl0 = 0;
        end else begin
            if ((q1.size() > 0) && !out_ready) m_st1 = sat(m_st1);
            if (q1.size() == 0)                m_bb1 = sat(m_bb1);
            if ((q0.size() > 0) && !out_ready) m_st0 = sat(m_st0);
            if (q0.size() == 0)                m_bb0 = sat(m_bb0);
            if (flush) begin
                m_fl1 = sat(m_fl1);
                m_fl0 = sat(m_fl0);
                q1.delete();
                q0.delete();
            end else begin
                if (of1) void'(q1.pop_front());
                if (of0) void'(q0.pop_front());
                if (in_valid && r1) q1.push_back(in_data);
                if (in_valid && r0) q0.push_back(in_data);
            end
            started = 1;
        end
    end

    always @(negedge CLK) begin
        if (live) begin
            chk("m1_valid", out_valid1, q1.size() > 0);
            chk("m1_data",  out_data1,  (q1.size() > 0) ? q1[0] : BUB);
            chk("m1_occ",   occ1,       q1.size());
            chk("m1_rdy",   in_ready1,  exp_rdy1());
            chk("m0_valid", out_valid0, q0.size() > 0);
            chk("m0_data",  out_data0,  (q0.size() > 0) ? q0[0] : BUB);
            chk("m0_occ",   occ0,       q0.size());
            chk("m0_rdy",   in_ready0,  exp_rdy0());
`ifdef PIPE_STAGE_PERF_EN
            chk("m1_stall",  stall1,  m_st1);
            chk("m1_bubble", bubble1, m_bb1);
            chk("m1_flush",  flushc1, m_fl1);
            chk("m0_stall",  stall0,  m_st0);
            chk("m0_bubble", bubble0, m_bb0);
            chk("m0_flush",  flushc0, m_fl0);
`endif
            if (!RST && !flush && out_valid1 && out_ready) got1.push_back(out_data1);
            if (!RST && !flush && out_valid0 && out_ready) got0.push_back(out_data0);
            if (!RST && flush && out_valid1 && out_ready) got1.push_back(out_data1);
            if (!RST && flush && out_valid0 && out_ready) got0.push_back(out_data0);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic lit1(input string nm, input logic v, input logic [DW-1:0] d,
                        input logic [1:0] o, input logic r);
        chk({nm, "_valid1"}, out_valid1, v);
        chk({nm, "_data1"},  out_data1,  d);
        chk({nm, "_occ1"},   occ1,       o);
        chk({nm, "_rdy1"},   in_ready1,  r);
    endtask

    task automatic lit0(input string nm, input logic v, input logic [DW-1:0] d,
                        input logic [1:0] o, input logic r);
        chk({nm, "_valid0"}, out_valid0, v);
        chk({nm, "_data0"},  out_data0,  d);
        chk({nm, "_occ0"},   occ0,       o);
        chk({nm, "_rdy0"},   in_ready0,  r);
    endtask

    initial begin
        logic [DW-1:0] exp1[$];
        logic [DW-1:0] exp0[$];
        RST = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

        // reset and bubble value
        step(); step();
        lit1("rst", 1'b0, BUB, 2'd0, 1'b0);
        lit0("rst", 1'b0, BUB, 2'd0, 1'b0);
        RST = 1'b0;
        step();
        lit1("rst_rel", 1'b0, BUB, 2'd0, 1'b1);
        lit0("rst_rel", 1'b0, BUB, 2'd0, 1'b1);

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            step();
            lit1("stream", 1'b1, DW'(i), 2'd1, 1'b1);
            chk("stream_data0", out_data0, DW'(i));
        end
        in_valid = 1'b0;
        step();
        lit1("drain", 1'b0, BUB, 2'd0, 1'b1);

        // backpressure into the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        step();
        lit1("bp_a", 1'b1, 16'h000A, 2'd1, 1'b1);
        in_data = 16'h000B;
        step();
        lit1("bp_full", 1'b1, 16'h000A, 2'd2, 1'b0);
        lit0("bp_hold", 1'b1, 16'h000A, 2'd1, 1'b0);
        out_ready = 1'b1;
        in_data   = 16'h0055;
        #1;
        chk("comb_rdy0", in_ready0, 1'b1);
        chk("full_rdy1", in_ready1, 1'b0);
        step();
        lit1("pop_a", 1'b1, 16'h000B, 2'd1, 1'b1);
        lit0("replace", 1'b1, 16'h0055, 2'd1, 1'b1);
        in_valid = 1'b0;
        step();
        lit1("pop_b", 1'b0, BUB, 2'd0, 1'b1);
        lit0("pop_55", 1'b0, BUB, 2'd0, 1'b1);

        // flush while full, with a competing push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        step();
        in_data = 16'h000B;
        step();
        flush   = 1'b1;
        in_data = 16'h000C;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        lit1("flush", 1'b0, BUB, 2'd0, 1'b1);
        lit0("flush", 1'b0, BUB, 2'd0, 1'b1);
        out_ready = 1'b1;
        step(); step();

        // reset with an entry held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0099;
        step();
        in_valid = 1'b0;
        chk("held_occ1", occ1, 2'd1);
        RST = 1'b1;
        step();
        lit1("midrst", 1'b0, BUB, 2'd0, 1'b0);
        RST = 1'b0;
        step();
        chk("midrst_rdy1", in_ready1, 1'b1);

`ifdef PIPE_STAGE_PERF_EN
        chk("perf_clr_flush1", flushc1, 4'd0);
        in_valid = 1'b1;
        in_data  = 16'h0077;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("stall_sat1", stall1, 4'hF);
        chk("stall_sat0", stall0, 4'hF);
        repeat (3) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            step();
        end
        chk("flush_cnt1", flushc1, 4'd3);
        chk("flush_cnt0", flushc0, 4'd3);
        RST = 1'b1;
        step();
        chk("perf_rst_stall1",  stall1,  4'd0);
        chk("perf_rst_bubble1", bubble1, 4'd0);
        chk("perf_rst_flush1",  flushc1, 4'd0);
        RST = 1'b0;
        step();
`endif

        out_ready = 1'b1;
        step(); step();

        // delivered payload order; 0x0C, 0x99 and 0x77 must never appear
        for (int i = 1; i <= 16; i++) begin
            exp1.push_back(DW'(i));
            exp0.push_back(DW'(i));
        end
        exp1.push_back(16'h000A);
        exp1.push_back(16'h000B);
        exp0.push_back(16'h000A);
        exp0.push_back(16'h0055);
        chk("order_len1", got1.size(), exp1.size());
        chk("order_len0", got0.size(), exp0.size());
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) chk("order1", got1[i], exp1[i]);
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) chk("order0", got0[i], exp0[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline latch for the 5-stage core. It replaces the per-stage hand-written latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries a packed payload. It adds a valid/ready handshake, a 2-entry skid buffer, flush with bubble injection, and occupancy reporting. Each stage's control and data fields are packed into one payload vector by the instantiating stage.

Parameters:
DATA_W, 128, payload width in bits (packed control + data fields).
BUBBLE_VAL, '0 (DATA_W bits), payload value driven on reset, on flush, and whenever out_valid=0.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
CNT_W, 32, perf counter width (used only with PIPE_STAGE_PERF_EN).

Ports:
CLK  in  1  clock, all state updates on posedge
RST  in  1  synchronous reset, active-high
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept in_data this cycle
in_data  in  DATA_W  upstream payload
flush  in  1  discard all held entries (branch/jump mispredict)
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_data  out  DATA_W  payload to next stage
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  cycles with out_valid & !out_ready (PERF_EN only)
bubble_cnt  out  CNT_W  cycles with !out_valid (PERF_EN only)
flush_cnt  out  CNT_W  flush assertions (PERF_EN only)

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Once out_valid is high, out_valid and out_data are held stable until out_fire.
- Reset (RST high at posedge), every output: state EMPTY, main/skid registers <= BUBBLE_VAL, out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=0. in_ready rises on the first posedge with RST low. Reset mid-transfer drops all held entries.
- Latency and rate: 1 cycle from in_fire to out_valid; throughput is 1 payload per cycle with out_ready held high.
- SKID=1 FSM, states PS_EMPTY / PS_BUSY / PS_FULL:
  - PS_EMPTY: in_fire -> PS_BUSY, main <= in_data.
  - PS_BUSY, in_fire & out_fire: stay PS_BUSY, main <= in_data.
  - PS_BUSY, in_fire & !out_ready: -> PS_FULL, skid <= in_data.
  - PS_BUSY, !in_fire & out_fire: -> PS_EMPTY, main <= BUBBLE_VAL.
  - PS_FULL: in_ready=0. out_fire -> PS_BUSY, main <= skid, skid <= BUBBLE_VAL.
  - in_ready is registered: in_ready = (next_state != PS_FULL).
  - Payload order is strictly FIFO; main is always the older entry.
- SKID=0:
  - Single register; skid logic absent; occupancy never exceeds 1.
  - in_ready = !out_valid | out_ready (combinational).
- Flush:
  - Priority below RST, above all other events.
  - Next state PS_EMPTY; main/skid <= BUBBLE_VAL; in_ready=1 next cycle.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered; the current-cycle output is not retracted.
- out_data = BUBBLE_VAL whenever out_valid=0. Bubbles are therefore inert: RegWr, dWEN and halt fields are zero with the default BUBBLE_VAL.
- occupancy: PS_EMPTY=0, PS_BUSY=1, PS_FULL=2; registered.

Optional Feature:
PIPE_STAGE_PERF_EN:
- Defined: stall_cnt, bubble_cnt and flush_cnt ports exist. Each is a CNT_W-bit counter, cleared by RST, incremented once per qualifying cycle, and saturating at all-ones (no wrap).
- Not defined: the three ports and all counter logic are absent; datapath behaviour is identical either way.

Decomposition:
- Package pipe_stage_pkg holds:
  - typedef enum logic [1:0] pipe_state_t {PS_EMPTY=2'd0, PS_BUSY=2'd1, PS_FULL=2'd2}.
  - localparam OCC_W=2.
- Stage payload structs stay in cpu_types_pkg.
- One sub-module: pipe_stage_perf, containing the three saturating counters, instantiated only under PIPE_STAGE_PERF_EN.

Test Plan:
1. Reset / bubble value: RST high 2 cycles, then low -> out_valid=0, out_data=BUBBLE_VAL, occupancy=0 during reset; in_ready=1 on the first cycle after RST drops.
2. Streaming: out_ready=1, in_data=0x01..0x10 on back-to-back cycles -> out_data 0x01..0x10 each exactly 1 cycle later, no gaps, occupancy stays 1.
3. Backpressure / skid: push 0xA then 0xB while out_ready=0 -> occupancy=2, in_ready=0. Raise out_ready -> 0xA then 0xB in order, in_ready=1 one cycle after the first pop.
4. Flush while full: with 0xA and 0xB held, assert flush for 1 cycle with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0. 0xC is never output.
5. SKID=0 build: out_ready=0 with 1 entry held -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally, and an in_fire in that same cycle replaces the entry.
6. PIPE_STAGE_PERF_EN with CNT_W=4: hold out_valid & !out_ready for 20 cycles -> stall_cnt saturates at 0xF. Assert flush 3 times -> flush_cnt=3. RST -> all counters 0.
